// File: rtl/unidad_control.sv
// unidad_control: Booth-algorithm sequencer for a signed shift-add multiplier datapath
// (4-bit A, 3-bit Q, 4-bit M, Q-1 flip-flop, add/subtract unit).
//
// Sequence per multiplication: IDLE -> CARGA -> (EXAMINA -> DESPLAZA) x N -> FIN -> IDLE.
// Latency start->fin is 2N+2 cycles, throughput one product per 2N+3 cycles.
//
// Ports:
//   clk      in  system clock, rising edge
//   reset    in  synchronous active-high reset, returns to IDLE
//   start    in  multiplication request, only sampled in IDLE
//   q0       in  datapath Q[0] (registered in the datapath)
//   qsub1    in  datapath Q-1 bit (registered in the datapath)
//   CargaA   out load adder result into A (Mealy, EXAMINA only)
//   CargaQ   out load multiplier operand into Q
//   CargaM   out load multiplicand operand (sign-extended) into M
//   desplaza out arithmetic shift right of A:Q:Q-1, also Q-1 load enable
//   resta    out 1 selects A-M, 0 selects A+M (Mealy, EXAMINA only)
//   limpia   out one-cycle clear of A and Q-1, ORed into datapath reset
//   fin      out one-cycle completion pulse, result valid from this cycle on
//   busy     out high whenever the unit is not in IDLE
module unidad_control #(
  parameter int unsigned N = 3  // Booth iterations = multiplier width, 1..7
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic qsub1,
  output logic CargaA,
  output logic CargaQ,
  output logic CargaM,
  output logic desplaza,
  output logic resta,
  output logic limpia,
  output logic fin,
  output logic busy
);

  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] NCnt = CntW'(N);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StCarga,
    StExamina,
    StDesplaza,
    StFin
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cont_q, cont_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cont_q  <= '0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cont_d   = cont_q;
    CargaA   = 1'b0;
    CargaQ   = 1'b0;
    CargaM   = 1'b0;
    desplaza = 1'b0;
    resta    = 1'b0;
    limpia   = 1'b0;
    fin      = 1'b0;
    busy     = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StCarga;
      end
      StCarga: begin
        CargaQ  = 1'b1;
        CargaM  = 1'b1;
        limpia  = 1'b1;
        cont_d  = NCnt;
        state_d = StExamina;
      end
      StExamina: begin
        // 01 -> A+M, 10 -> A-M, 00/11 -> no load
        CargaA  = q0 ^ qsub1;
        resta   = q0 & ~qsub1;
        state_d = StDesplaza;
      end
      StDesplaza: begin
        desplaza = 1'b1;
        cont_d   = cont_q - CntOne;
        // Decision uses the pre-decrement count: last shift when one iteration is left
        state_d  = (cont_q == CntOne) ? StFin : StExamina;
      end
      StFin: begin
        fin     = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_unidad_control.sv
// Bench for unidad_control: an N=3 instance drives a behavioural Booth datapath kept here,
// and an N=1 instance is fed random q0/qsub1. Expected controls come from the cycle index
// since start; products are checked against signed integer multiplication.
module tb_unidad_control;

  logic clk;
  logic reset;
  logic start;

  // N=3 instance and its datapath
  logic ca3, cq3, cm3, ds3, rs3, lp3, fn3, bs3;
  logic [3:0] a_q = '0;
  logic [2:0] q_q = '0;
  logic       qm1_q = 1'b0;
  logic [3:0] m_q = '0;
  logic [2:0] em_r, eq_r;

  // N=1 instance with free-running random Booth inputs
  logic ca1, cq1, cm1, ds1, rs1, lp1, fn1, bs1;
  logic qr1, qsr1;

  int   tests = 0;
  int   fails = 0;
  int   k3 = 0;
  int   k1 = 0;
  logic [2:0] xm = '0, xq = '0;
  logic       have = 1'b0;
  logic       running = 1'b0;

  unidad_control #(.N(3)) u_dut3 (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .q0      (q_q[0]),
    .qsub1   (qm1_q),
    .CargaA  (ca3),
    .CargaQ  (cq3),
    .CargaM  (cm3),
    .desplaza(ds3),
    .resta   (rs3),
    .limpia  (lp3),
    .fin     (fn3),
    .busy    (bs3)
  );

  unidad_control #(.N(1)) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .q0      (qr1),
    .qsub1   (qsr1),
    .CargaA  (ca1),
    .CargaQ  (cq1),
    .CargaM  (cm1),
    .desplaza(ds1),
    .resta   (rs1),
    .limpia  (lp1),
    .fin     (fn1),
    .busy    (bs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Cycle index within a run: 0 idle, 1 load, 2..2N+1 examine/shift, 2N+2 done
  function automatic int next_k(input int nn, input int k, input logic r, input logic s);
    if (r) return 0;
    if (k == 0) return s ? 1 : 0;
    if (k == 2 * nn + 2) return 0;
    return k + 1;
  endfunction

  // {busy, fin, limpia, resta, desplaza, CargaM, CargaQ, CargaA}
  function automatic logic [7:0] exp_out(input int nn, input int k, input logic q0,
                                         input logic qs);
    logic [7:0] v;
    v = '0;
    if (k == 1) v = 8'b1010_0110;
    else if (k == 2 * nn + 2) v = 8'b1100_0000;
    else if (k >= 2 && (k % 2) == 0) begin
      v[7] = 1'b1;
      v[4] = q0 & ~qs;
      v[0] = q0 ^ qs;
    end else if (k >= 3) v = 8'b1000_1000;
    return v;
  endfunction

  function automatic logic excl_ok(input logic [7:0] v);
    logic wr;
    wr = v[5] | v[2] | v[1];
    return !(v[0] && v[3]) && !((v[0] || v[3]) && wr);
  endfunction

  function automatic logic [5:0] prod(input logic [2:0] m, input logic [2:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[5:0];
  endfunction

  // Reference state and datapath, updated on the DUT's active edge
  always @(posedge clk) begin
    int n3;
    n3 = next_k(3, k3, reset, start);
    k3 <= n3;
    k1 <= next_k(1, k1, reset, start);
    if (n3 == 1) begin
      xm <= em_r;
      xq <= eq_r;
    end
    if (reset) have <= 1'b0;
    else if (k3 == 8) have <= 1'b1;
    else if (n3 == 1) have <= 1'b0;

    if (cq3) q_q <= eq_r;
    if (cm3) m_q <= {em_r[2], em_r};
    if (ca3) a_q <= rs3 ? a_q - m_q : a_q + m_q;
    if (ds3) {a_q, q_q, qm1_q} <= {a_q[3], a_q, q_q};
    if (lp3 || reset) begin
      a_q   <= '0;
      qm1_q <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (running) begin
      logic [7:0] o3, o1;
      #2;
      o3 = {bs3, fn3, lp3, rs3, ds3, cm3, cq3, ca3};
      o1 = {bs1, fn1, lp1, rs1, ds1, cm1, cq1, ca1};
      check_eq("ctl_n3", {24'h0, o3}, {24'h0, exp_out(3, k3, q_q[0], qm1_q)});
      check_eq("ctl_n1", {24'h0, o1}, {24'h0, exp_out(1, k1, qr1, qsr1)});
      check_eq("excl_n3", {31'h0, excl_ok(o3)}, 32'h1);
      check_eq("excl_n1", {31'h0, excl_ok(o1)}, 32'h1);
      if (k3 == 8) check_eq("prod", {26'h0, a_q[2:0], q_q}, {26'h0, prod(xm, xq)});
      else if (k3 == 0 && have) check_eq("hold", {26'h0, a_q[2:0], q_q}, {26'h0, prod(xm, xq)});
    end
  end

  task automatic cyc(input logic s, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = s;
      reset = r;
      qr1   = 1'($urandom);
      qsr1  = 1'($urandom);
    end
  endtask

  task automatic run_ops(input logic [2:0] m, input logic [2:0] q);
    @(negedge clk);
    em_r = m;
    eq_r = q;
    cyc(1'b1, 1'b0, 1);
    cyc(1'b0, 1'b0, 10);
  endtask

  initial begin
    start = 1'b0;
    reset = 1'b1;
    qr1   = 1'b0;
    qsr1  = 1'b0;
    em_r  = '0;
    eq_r  = '0;
    @(posedge clk);
    running = 1'b1;
    cyc(1'b0, 1'b1, 2);
    cyc(1'b0, 1'b0, 2);

    run_ops(3'b011, 3'b010);  // 3 x 2
    run_ops(3'b101, 3'b011);  // -3 x 3
    run_ops(3'b100, 3'b100);  // -4 x -4

    // Start pulses while busy are ignored
    em_r = 3'b010;
    eq_r = 3'b111;
    cyc(1'b1, 1'b0, 1);
    cyc(1'b0, 1'b0, 2);
    cyc(1'b1, 1'b0, 1);
    cyc(1'b0, 1'b0, 4);
    cyc(1'b1, 1'b0, 1);
    cyc(1'b0, 1'b0, 4);

    // Start held high: back-to-back runs
    em_r = 3'b111;
    eq_r = 3'b101;
    cyc(1'b1, 1'b0, 18);
    cyc(1'b0, 1'b0, 12);

    // Reset in cycle 5, new start in cycle 7
    em_r = 3'b011;
    eq_r = 3'b011;
    cyc(1'b1, 1'b0, 1);
    cyc(1'b0, 1'b0, 4);
    cyc(1'b0, 1'b1, 1);
    cyc(1'b0, 1'b0, 1);
    cyc(1'b1, 1'b0, 1);
    cyc(1'b0, 1'b0, 12);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (k3 == 0) begin
        em_r = 3'($urandom);
        eq_r = 3'($urandom);
      end
      start = ($urandom % 3) == 0;
      reset = ($urandom % 60) == 0;
      qr1   = 1'($urandom);
      qsr1  = 1'($urandom);
    end
    cyc(1'b0, 1'b0, 12);

    @(negedge clk);
    running = 1'b0;
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unidad_control.md
# unidad_control

Booth-algorithm control unit that sequences the signed shift-add multiplier datapath (4-bit A, 3-bit Q, 4-bit M, Q-1 flip-flop, add/subtract unit). It accepts a start request, loads the operands, runs N examine/shift iterations driven by the {Q0, Q-1} bit pair, and signals completion. Top level: datapath and this unit share `clk`. The unit's `limpia` output is ORed into the datapath `reset`.

## Interface
- `N`, default 3: number of Booth iterations, equal to the multiplier width. Legal range 1..7.
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: synchronous, active-high. Returns the unit to IDLE.
- `start`, input, 1: request a multiplication. Sampled only in IDLE.
- `q0`, input, 1: datapath Q[0].
- `qsub1`, input, 1: datapath Q-1 bit.
- `CargaA`, output, 1: load the adder result into A.
- `CargaQ`, output, 1: load `entrada_q` into Q.
- `CargaM`, output, 1: load `entrada_m` (sign-extended) into M.
- `desplaza`, output, 1: arithmetic shift right of A:Q:Q-1. Also serves as the Q-1 load enable.
- `resta`, output, 1: selects A−M (1) or A+M (0).
- `limpia`, output, 1: one-cycle clear of A and Q-1.
- `fin`, output, 1: completion pulse. The result on A[2:0]:Q is valid from this cycle on.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, CARGA, EXAMINA, DESPLAZA, FIN. State is registered.
- Counter `cont` is ceil(log2(N+1)) bits wide.
- IDLE:
  - All outputs are 0.
  - If `start`=1, go to CARGA. Otherwise stay.
- CARGA:
  - `CargaQ`=`CargaM`=`limpia`=1.
  - `cont` is loaded with N.
  - Go to EXAMINA.
- EXAMINA:
  - `CargaA` = q0 XOR qsub1.
  - `resta` = q0 AND NOT qsub1.
  - Bit pair 00 or 11: no load.
  - Go to DESPLAZA.
- DESPLAZA:
  - `desplaza`=1.
  - `cont` decrements by 1.
  - If `cont`==1 before the decrement, go to FIN. Otherwise go to EXAMINA.
- FIN:
  - `fin`=1 for exactly one cycle.
  - Go to IDLE.
- Output types:
  - `resta` and `CargaA` are Mealy outputs on `q0`/`qsub1`. Both inputs are registered in the datapath, so there is no combinational loop.
  - All other outputs decode the state only.
- `resta` is 0 in every state other than EXAMINA.
- `start` outside IDLE is ignored. It is not queued.
- The datapath holds the result after FIN until the next CARGA. The unit never clears it on its own.
- At most one of `CargaA` and `desplaza` is high in any cycle. They never overlap with `CargaQ`, `CargaM` or `limpia`.

## Timing
- Cycle 0 is the cycle with state=IDLE and `start`=1.
- Cycle 1: CARGA.
- Cycles 2..2N+1: alternating EXAMINA (even cycles) and DESPLAZA (odd cycles).
- Cycle 2N+2: FIN, `fin`=1.
- Cycle 2N+3: IDLE, `busy`=0.
- For N=3: `fin` is high in cycle 8 and the next `start` is accepted in cycle 9.
- Latency from start to fin is 2N+2 cycles. Throughput is one multiplication per 2N+3 cycles.
- `busy` rises in cycle 1 and falls in cycle 2N+3.
- Reset:
  - `reset`=1 at any edge forces IDLE, `cont`=0 and all outputs 0 in the following cycle, including mid-operation.
  - Reset has priority over `start`.
  - A partially computed datapath result is undefined after an aborted run.
- If `start` is held high continuously, a new run begins on each return to IDLE.

## Test plan
- **3×2** (`entrada_m`=011, `entrada_q`=010, N=3):
  - `CargaA` pulses in cycle 4 with `resta`=1, and in cycle 6 with `resta`=0.
  - `fin` is high in cycle 8.
  - Result 6'b000110.
- **−3×3** (101×011):
  - `CargaA`/`resta`=1 in cycle 2 and `CargaA`/`resta`=0 in cycle 6.
  - Result 6'b110111 (−9).
- **−4×−4** (100×100):
  - Single `CargaA` in cycle 6 with `resta`=1.
  - Result 6'b010000 (16).
- **Busy-time start and back-to-back runs:**
  - Pulse `start` in cycles 3 and 8: both are ignored, and exactly one `fin` appears, in cycle 8.
  - Hold `start` high from cycle 0: `fin` appears in cycles 8 and 17.
- **Reset mid-run:** assert `reset` in cycle 5.
  - Cycle 6: state IDLE, all outputs 0, `busy`=0.
  - A new `start` in cycle 7 gives `fin` in cycle 15.
- **N=1 parameterisation:**
  - Sequence is CARGA, EXAMINA, DESPLAZA, then FIN in cycle 4.
  - Check the one-hot/mutual-exclusion property of the outputs every cycle with an assertion.
